// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   RESET_PC_DEF  : default first fetch address after reset
//   WORD_BYTES    : bytes per instruction word (PC step)
//   fetch_state_e : fetch FSM states
//   fetch_entry_t : one buffered instruction (PC + word)
//   align_word()  : force an address onto a word boundary
package mips_fetch_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam int          WORD_BYTES   = 4;

   typedef enum logic {
      FS_RUN   = 1'b0,
      FS_FLUSH = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } fetch_entry_t;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return addr & ~32'(WORD_BYTES - 1);
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order instruction queue: synchronous FIFO of {pc, data} entries.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   push_i/wr_pc_i/wr_data_i : write one entry
//   pop_i               : drop the head entry
//   flush_i             : empty the queue (wins over push and pop)
//   rd_pc_o/rd_data_o   : head entry (registered storage)
//   full_o/empty_o/count_o : occupancy status
module fetch_queue
   import mips_fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic [31:0]                wr_pc_i,
   input  logic [31:0]                wr_data_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output logic [31:0]                rd_pc_o,
   output logic [31:0]                rd_data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   fetch_entry_t   mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q;
   logic [AW-1:0]  rd_ptr_q;
   logic [CW-1:0]  count_q;
   logic           do_push;
   logic           do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;

   assign do_pop  = pop_i & ~empty_o;
   // A push into a full queue is only legal when the head leaves the same cycle.
   assign do_push = push_i & (~full_o | do_pop);

   assign rd_pc_o   = mem_q[rd_ptr_q].pc;
   assign rd_data_o = mem_q[rd_ptr_q].data;

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= '{pc: wr_pc_i, data: wr_data_i};
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: issues word-aligned instruction reads, buffers returned words with
// their PC and hands them downstream; redirects flush buffered and in-flight fetches.
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   fetch_en                        : permit new requests
//   imem_req_valid/ready/addr       : request channel to instruction memory
//   imem_rsp_valid/data             : in-order read responses
//   redirect_valid/pc               : branch/jump restart
//   inst_valid/ready/data/pc/pc_add4: instruction channel to decode
//
// state    | meaning
// FS_RUN   | normal fetching, every response is kept
// FS_FLUSH | stale responses from before a redirect are still due and get dropped
module inst_fetch_unit
   import mips_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter int          QDEPTH    = 2,
   parameter int          MAX_OUTST = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   output logic [31:0] inst_pc_add4
);

   localparam int OW = $clog2(MAX_OUTST + 1);
   localparam int CW = $clog2(QDEPTH + 1);

   fetch_state_e  state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [OW-1:0] outst_q, outst_d;
   logic [OW-1:0] drop_q, drop_d;

   logic          req_acc;
   logic          q_push, q_pop, q_flush;
   logic          q_full, q_empty;
   logic [CW-1:0] q_count;
   logic [31:0]   q_rd_pc, q_rd_data;
   logic [31:0]   rsp_pc;
   logic [CW:0]   occ_sum;

   // Words already buffered plus words still owed by memory must fit the queue.
   assign occ_sum = (CW+1)'(q_count) + (CW+1)'(outst_q);

   assign imem_req_valid = rst_n & fetch_en
                         & (outst_q < OW'(MAX_OUTST))
                         & (occ_sum < (CW+1)'(QDEPTH));
   assign imem_req_addr  = fetch_pc_q;
   assign req_acc        = imem_req_valid & imem_req_ready;

   // Once the stale words are drained, everything in flight is a contiguous run
   // ending just below fetch_pc, so the oldest response sits outst words back.
   assign rsp_pc = fetch_pc_q - (32'(outst_q) * 32'(WORD_BYTES));

   assign q_flush = redirect_valid;
   assign q_push  = imem_rsp_valid & (drop_q == '0) & ~redirect_valid;
   assign q_pop   = inst_valid & inst_ready & ~redirect_valid;

   fetch_queue #(
      .DEPTH (QDEPTH)
   ) u_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_i    (q_push),
      .wr_pc_i   (rsp_pc),
      .wr_data_i (imem_rsp_data),
      .pop_i     (q_pop),
      .flush_i   (q_flush),
      .rd_pc_o   (q_rd_pc),
      .rd_data_o (q_rd_data),
      .full_o    (q_full),
      .empty_o   (q_empty),
      .count_o   (q_count)
   );

   assign inst_valid   = ~q_empty;
   assign inst_data    = inst_valid ? q_rd_data : '0;
   assign inst_pc      = inst_valid ? q_rd_pc : '0;
   assign inst_pc_add4 = inst_valid ? (q_rd_pc + 32'(WORD_BYTES)) : '0;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      outst_d    = outst_q;
      drop_d     = drop_q;

      if (req_acc) begin
         fetch_pc_d = fetch_pc_q + 32'(WORD_BYTES);
         outst_d    = outst_q + OW'(1);
      end
      if (imem_rsp_valid) begin
         outst_d = outst_d - OW'(1);
         if (drop_q != '0) begin
            drop_d = drop_q - OW'(1);
         end
      end
      // Everything still owed after this cycle predates the new target.
      if (redirect_valid) begin
         fetch_pc_d = align_word(redirect_pc);
         drop_d     = outst_d;
      end

      case (state_q)
         FS_RUN:   if (redirect_valid && (outst_d != '0)) state_d = FS_FLUSH;
         FS_FLUSH: if (drop_d == '0) state_d = FS_RUN;
         default:  state_d = FS_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FS_RUN;
         fetch_pc_q <= RESET_PC;
         outst_q    <= '0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
      end
   end

   a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
      imem_rsp_valid |-> (outst_q != '0));

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      (q_push && q_full) |-> q_pop);

   a_drop_bounded: assert property (@(posedge clk) disable iff (!rst_n)
      drop_q <= outst_q);

endmodule
